fp_add_norm_round: RTL and testbench

Two-stage pipelined normalize-and-round stage of the FP64 adder. Consumes the 107-bit mantissa sum/difference, the provisional exponent, and the 7-bit normalization shift produced by the shift-amount stage. Produces a packed IEEE-754 binary64 result using round-to-nearest-even. Uses a valid/ready handshake on both sides.

---
 rtl/fp_add_norm_round.sv | 128 ++++++++++++
 tb/tb_fp_add_norm_round.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_norm_round.sv
// FP64 adder normalize/round back end: stage 1 normalizes the mantissa sum, stage 2 applies RNE and packs.
// Define FP_NORM_FLAGS_EN to build the {overflow, underflow, inexact} flag logic; otherwise out_flags is 0.
module fp_add_norm_round (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sign,
  input  logic [10:0]  in_exp,
  input  logic [106:0] in_sum,
  input  logic         in_add,
  input  logic [6:0]   in_shift,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_result,
  output logic [2:0]   out_flags
);

  logic               s1_valid_q, s1_sign_q, s1_sticky_q, s1_zero_q;
  logic signed [12:0] s1_exp_q;
  logic [104:0]       s1_m_q;
  logic               s2_valid_q;
  logic [63:0]        s2_result_q;
  logic               s1_load, s2_load;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Hidden bit is implied after normalization, so only bits below it are kept in s1.
  logic               sh_add;
  logic [5:0]         sh_sub;
  logic [104:0]       m_d;
  logic               sticky_d, zero_d;
  logic signed [12:0] exp_d;

  always_comb begin
    sh_add = (in_shift != 7'd0);
    sh_sub = (in_shift > 7'd53) ? 6'd53 : in_shift[5:0];
    if (in_add) begin
      m_d      = sh_add ? in_sum[105:1] : in_sum[104:0];
      sticky_d = sh_add & in_sum[0];
      exp_d    = {2'b00, in_exp} + {12'd0, sh_add};
    end else begin
      m_d      = in_sum[104:0] << sh_sub;
      sticky_d = 1'b0;
      exp_d    = {2'b00, in_exp} - {7'd0, sh_sub};
    end
    zero_d = (in_sum == 107'd0) || (!in_add && (sh_sub == 6'd53));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_m_q      <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q   <= in_sign;
        s1_sticky_q <= sticky_d;
        s1_zero_q   <= zero_d;
        s1_exp_q    <= exp_d;
        s1_m_q      <= m_d;
      end
    end
  end

  logic [51:0]        frac;
  logic               guard, rnd, sticky, inc;
  logic [52:0]        frac_sum;
  logic signed [12:0] exp_r;
  logic               is_uf, is_of;
  logic [63:0]        result_d;

  always_comb begin
    frac     = s1_m_q[104:53];
    guard    = s1_m_q[52];
    rnd      = s1_m_q[51];
    sticky   = (|s1_m_q[50:0]) | s1_sticky_q;
    inc      = guard & (rnd | sticky | frac[0]);
    frac_sum = {1'b0, frac} + {52'd0, inc};
    exp_r    = s1_exp_q + {12'd0, frac_sum[52]};
    is_uf    = !s1_zero_q && (exp_r <= 13'sd0);
    is_of    = !s1_zero_q && !is_uf && (exp_r >= 13'sd2047);
    if (s1_zero_q)  result_d = 64'h0;
    else if (is_uf) result_d = {s1_sign_q, 63'd0};
    else if (is_of) result_d = {s1_sign_q, 11'h7FF, 52'd0};
    else            result_d = {s1_sign_q, exp_r[10:0], frac_sum[51:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= 64'h0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_result_q <= result_d;
    end
  end

`ifdef FP_NORM_FLAGS_EN
  logic [2:0] flags_d, s2_flags_q;

  always_comb begin
    if (s1_zero_q)          flags_d = 3'b000;
    else if (is_uf)         flags_d = 3'b011;
    else if (is_of)         flags_d = 3'b101;
    else                    flags_d = {2'b00, guard | rnd | sticky};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      s2_flags_q <= 3'b000;
    else if (s2_load && s1_valid_q)  s2_flags_q <= flags_d;
  end

  assign out_flags = s2_flags_q;
`else
  assign out_flags = 3'b000;
`endif

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;

endmodule

// File: tb/tb_fp_add_norm_round.sv
// Bench for fp_add_norm_round: directed test-plan cases, backpressure, reset, then a random stream vs a reference model.
module tb_fp_add_norm_round;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sign = 1'b0;
  logic [10:0]  in_exp = '0;
  logic [106:0] in_sum = '0;
  logic         in_add = 1'b0;
  logic [6:0]   in_shift = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_result;
  logic [2:0]   out_flags;

  int total = 0;
  int bad = 0;

`ifdef FP_NORM_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  fp_add_norm_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sum(in_sum), .in_add(in_add), .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] fl(input logic [2:0] f);
    return FLAGS_ON ? f : 3'b000;
  endfunction

  // Value-level model: round the kept 53-bit significand by comparing the discarded remainder against one half.
  function automatic logic [66:0] ref_model(input logic sg, input logic [10:0] ex,
                                            input logic [106:0] sum, input logic ad, input logic [6:0] shift);
    int sh;
    int e;
    logic [106:0] m;
    logic [52:0] rem, half, sig;
    bit st, up, inx;
    if (ad) sh = (int'(shift) > 1) ? 1 : int'(shift);
    else    sh = (int'(shift) > 53) ? 53 : int'(shift);
    if (sum == 107'd0 || (!ad && sh == 53)) return 67'd0;
    if (ad) begin
      m  = sum >> sh;
      st = (sh == 1) && sum[0];
      e  = int'(ex) + sh;
    end else begin
      m  = sum << sh;
      st = 1'b0;
      e  = int'(ex) - sh;
    end
    sig  = {1'b0, m[104:53]};
    rem  = m[52:0];
    half = 53'd1 << 52;
    up   = (rem > half) || ((rem == half) && (st || sig[0]));
    inx  = (rem != 53'd0) || st;
    sig  = sig + 53'(up);
    if (sig[52]) begin
      sig = 53'd0;
      e   = e + 1;
    end
    if (e <= 0)    return {3'b011, sg, 63'd0};
    if (e >= 2047) return {3'b101, sg, 11'h7FF, 52'd0};
    return {2'b00, inx, sg, 11'(e), sig[51:0]};
  endfunction

  task automatic put(input logic sg, input logic [10:0] ex, input logic [106:0] sm,
                     input logic ad, input logic [6:0] sh);
    in_sign  = sg;
    in_exp   = ex;
    in_sum   = sm;
    in_add   = ad;
    in_shift = sh;
  endtask

  task automatic directed(input string tag, input logic sg, input logic [10:0] ex, input logic [106:0] sm,
                          input logic ad, input logic [6:0] sh, input logic [63:0] er, input logic [2:0] ef);
    @(negedge clk);
    put(sg, ex, sm, ad, sh);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, "/in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "/valid_early"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "/valid"}, out_valid, 1);
    chk({tag, "/result"}, out_result, er);
    chk({tag, "/flags"}, out_flags, fl(ef));
  endtask

  task automatic gen_beat(output logic sg, output logic [10:0] ex, output logic [106:0] sm,
                          output logic ad, output logic [6:0] sh);
    logic [127:0] r;
    int top;
    int cat;
    r   = {$urandom(), $urandom(), $urandom(), $urandom()};
    sg  = 1'($urandom());
    ad  = 1'($urandom());
    cat = int'($urandom_range(7, 0));
    if (cat == 0)      ex = 11'($urandom_range(60, 1));
    else if (cat == 1) ex = 11'($urandom_range(2047, 2030));
    else               ex = 11'($urandom_range(2046, 1));
    if (ad) begin
      sh = 7'($urandom_range(1, 0));
      if (sh == 7'd1) sm = r[106:0] | (107'd1 << 106);
      else            sm = (r[106:0] & ((107'd1 << 105) - 107'd1)) | (107'd1 << 105);
    end else begin
      sh = 7'($urandom_range(53, 0));
      if (sh == 7'd53) sm = r[106:0];
      else begin
        top = 105 - int'(sh);
        sm  = (r[106:0] & ((107'd1 << top) - 107'd1)) | (107'd1 << top);
      end
    end
    if ($urandom_range(5, 0) == 0) sm = sm & ~((107'd1 << 52) - 107'd1);
  endtask

  logic [66:0]  exp_q[$];
  logic [66:0]  mv;
  logic         g_sg, g_ad, holding;
  logic [10:0]  g_ex;
  logic [106:0] g_sm;
  logic [6:0]   g_sh;

  initial begin
    #1;
    chk("rst/out_valid", out_valid, 0);
    chk("rst/out_result", out_result, 64'h0);
    chk("rst/out_flags", out_flags, 0);
    chk("rst/in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    directed("one_plus_one", 1'b0, 11'd1023, 107'd1 << 106, 1'b1, 7'd1, 64'h4000000000000000, 3'b000);
    directed("1p5_minus_1", 1'b0, 11'd1023, 107'd1 << 104, 1'b0, 7'd1, 64'h3FE0000000000000, 3'b000);
    directed("tie_even", 1'b0, 11'd1023, (107'd1 << 105) | (107'd1 << 52), 1'b0, 7'd0,
             64'h3FF0000000000000, 3'b001);
    directed("tie_odd", 1'b0, 11'd1023, (107'd1 << 105) | (107'd1 << 53) | (107'd1 << 52), 1'b0, 7'd0,
             64'h3FF0000000000002, 3'b001);
    directed("overflow", 1'b0, 11'd2046, 107'd1 << 106, 1'b1, 7'd1, 64'h7FF0000000000000, 3'b101);
    directed("underflow", 1'b0, 11'd3, 107'd1 << 100, 1'b0, 7'd5, 64'h0, 3'b011);
    directed("underflow_neg", 1'b1, 11'd3, 107'd1 << 100, 1'b0, 7'd5, 64'h8000000000000000, 3'b011);
    directed("zero_shift53", 1'b1, 11'd1000, 107'd1 << 52, 1'b0, 7'd53, 64'h0, 3'b000);
    directed("zero_sum", 1'b1, 11'd1000, 107'd0, 1'b1, 7'd0, 64'h0, 3'b000);
    directed("add_sticky", 1'b0, 11'd1023, (107'd1 << 106) | (107'd1 << 53) | 107'd1, 1'b1, 7'd1,
             64'h4000000000000001, 3'b001);
    directed("round_carry", 1'b1, 11'd1023, (107'd1 << 106) - (107'd1 << 52), 1'b0, 7'd0,
             64'hC000000000000000, 3'b001);
    directed("round_to_inf", 1'b0, 11'd2046, (107'd1 << 106) - (107'd1 << 52), 1'b0, 7'd0,
             64'h7FF0000000000000, 3'b101);
    directed("clamp_add", 1'b0, 11'd1023, 107'd1 << 106, 1'b1, 7'd9, 64'h4000000000000000, 3'b000);
    directed("clamp_sub", 1'b0, 11'd1023, 107'd1 << 40, 1'b0, 7'd100, 64'h0, 3'b000);

    // Backpressure: three beats offered into a stalled pipe, only two fit.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    put(1'b0, 11'd1023, 107'd1 << 106, 1'b1, 7'd1);
    #1 chk("bp/ready_a", in_ready, 1);
    @(negedge clk);
    put(1'b0, 11'd1023, 107'd1 << 104, 1'b0, 7'd1);
    #1;
    chk("bp/ready_b", in_ready, 1);
    chk("bp/valid_b", out_valid, 0);
    @(negedge clk);
    put(1'b0, 11'd1023, (107'd1 << 105) | (107'd1 << 53) | (107'd1 << 52), 1'b0, 7'd0);
    #1;
    chk("bp/ready_c", in_ready, 0);
    chk("bp/valid_c", out_valid, 1);
    chk("bp/hold_a", out_result, 64'h4000000000000000);
    @(negedge clk);
    #1;
    chk("bp/ready_c2", in_ready, 0);
    chk("bp/hold_a2", out_result, 64'h4000000000000000);
    chk("bp/hold_fl", out_flags, 0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp/ready_drain", in_ready, 1);
    chk("bp/res_a", out_result, 64'h4000000000000000);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp/valid_b2", out_valid, 1);
    chk("bp/res_b", out_result, 64'h3FE0000000000000);
    @(negedge clk);
    #1;
    chk("bp/valid_c2", out_valid, 1);
    chk("bp/res_c", out_result, 64'h3FF0000000000002);
    chk("bp/flags_c", out_flags, fl(3'b001));
    @(negedge clk);
    #1 chk("bp/empty", out_valid, 0);

    // Asynchronous reset with both stages full.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    put(1'b1, 11'd1023, 107'd1 << 106, 1'b1, 7'd1);
    @(negedge clk);
    put(1'b0, 11'd1023, 107'd1 << 106, 1'b1, 7'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rstmid/full_valid", out_valid, 1);
    chk("rstmid/full_ready", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid/out_valid", out_valid, 0);
    chk("rstmid/out_result", out_result, 64'h0);
    chk("rstmid/in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rstmid/no_stale", out_valid, 0);
      @(negedge clk);
    end

    // Random stream with random backpressure against the reference model.
    holding = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (!holding) begin
        in_valid = (cyc < 600) && ($urandom_range(3, 0) != 0);
        if (in_valid) begin
          gen_beat(g_sg, g_ex, g_sm, g_ad, g_sh);
          put(g_sg, g_ex, g_sm, g_ad, g_sh);
        end
      end
      out_ready = (cyc >= 600) || ($urandom_range(3, 0) != 0);
      #1;
      chk("rnd/in_ready", in_ready, (out_ready || exp_q.size() < 2) ? 1 : 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd/spurious", out_valid, 0);
        end else begin
          mv = exp_q.pop_front();
          chk("rnd/result", out_result, mv[63:0]);
          chk("rnd/flags", out_flags, fl(mv[66:64]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_sign, in_exp, in_sum, in_add, in_shift));
        holding = 1'b0;
      end else begin
        holding = in_valid;
      end
    end
    chk("rnd/drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
